// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the sequential ALU. This package holds
//               the 5-bit opcode constants, the FSM state enum and a small
//               opcode-decode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Base (single-cycle) opcodes, bit4 = 0
    localparam logic [4:0] c_op_add    = 5'b00000;
    localparam logic [4:0] c_op_sub    = 5'b00001;
    localparam logic [4:0] c_op_slt    = 5'b00010;
    localparam logic [4:0] c_op_sltu   = 5'b00011;
    localparam logic [4:0] c_op_srl    = 5'b00100;
    localparam logic [4:0] c_op_sll    = 5'b00101;
    localparam logic [4:0] c_op_sra    = 5'b00110;
    localparam logic [4:0] c_op_xor    = 5'b01000;
    localparam logic [4:0] c_op_or     = 5'b01001;
    localparam logic [4:0] c_op_and    = 5'b01010;

    // Multiply/divide opcodes, bit4 = 1 and bit3 = 0
    localparam logic [4:0] c_op_mul    = 5'b10000;
    localparam logic [4:0] c_op_mulh   = 5'b10001;
    localparam logic [4:0] c_op_mulhsu = 5'b10010;
    localparam logic [4:0] c_op_mulhu  = 5'b10011;
    localparam logic [4:0] c_op_div    = 5'b10100;
    localparam logic [4:0] c_op_divu   = 5'b10101;
    localparam logic [4:0] c_op_rem    = 5'b10110;
    localparam logic [4:0] c_op_remu   = 5'b10111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The 10xxx block is the iterative multiply/divide group; 11xxx is unused.
    function automatic logic is_mdiv_op(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/response bundle of the sequential ALU.
// Ports       : i_valid/o_ready  request handshake
//               i_op_a, i_op_b   operands (N bits)
//               i_alu_op         5-bit opcode
//               i_flush          abort in-flight operation
//               o_valid          one-cycle result strobe
//               o_alu_data       result (N bits), held between strobes
//               o_busy           iterative operation in progress
//               Modport master drives requests; modport slave is the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int N = 32
);
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_op_a;
    logic [N-1:0] i_op_b;
    logic [4:0]   i_alu_op;
    logic         i_flush;
    logic         o_valid;
    logic [N-1:0] o_alu_data;
    logic         o_busy;

    modport master (
        output i_valid, i_op_a, i_op_b, i_alu_op, i_flush,
        input  o_ready, o_valid, o_alu_data, o_busy
    );

    modport slave (
        input  i_valid, i_op_a, i_op_b, i_alu_op, i_flush,
        output o_ready, o_valid, o_alu_data, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_base_n.sv
`default_nettype none
// ============================================================================
// Module      : alu_base_n
// Description : Purely combinational single-cycle ALU datapath (add, sub,
//               compares, shifts, logic). Unlisted opcodes give zero.
// Ports       : i_op_a, i_op_b  operands (N bits)
//               i_alu_op        5-bit opcode
//               o_result        result (N bits)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_base_n
    import alu_seq_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic [N-1:0] i_op_a,
    input  logic [N-1:0] i_op_b,
    input  logic [4:0]   i_alu_op,
    output logic [N-1:0] o_result
);

    logic [SHW-1:0] w_shamt;
    logic           w_lt_s;
    logic           w_lt_u;

    assign w_shamt = i_op_b[SHW-1:0];
    assign w_lt_s  = ($signed(i_op_a) < $signed(i_op_b));
    assign w_lt_u  = (i_op_a < i_op_b);

    always_comb begin
        o_result = '0;
        case (i_alu_op)
            c_op_add:  o_result = i_op_a + i_op_b;
            c_op_sub:  o_result = i_op_a - i_op_b;
            c_op_slt:  o_result = {{(N-1){1'b0}}, w_lt_s};
            c_op_sltu: o_result = {{(N-1){1'b0}}, w_lt_u};
            c_op_srl:  o_result = i_op_a >> w_shamt;
            c_op_sll:  o_result = i_op_a << w_shamt;
            c_op_sra:  o_result = $signed(i_op_a) >>> w_shamt;
            c_op_xor:  o_result = i_op_a ^ i_op_b;
            c_op_or:   o_result = i_op_a | i_op_b;
            c_op_and:  o_result = i_op_a & i_op_b;
            default:   o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU. Base ops complete in one cycle; multiply and
//               divide iterate one bit per cycle on operand magnitudes over N
//               cycles, sharing one counter and one 2N-bit working register.
//               Divide-by-zero and signed overflow skip the iteration.
// Ports       : i_clk    clock, rising edge
//               i_reset  synchronous active-high reset
//               bus      alu_seq_if slave (request, operands, flush, result)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic     i_clk,
    input  logic     i_reset,
    alu_seq_if.slave bus
);

    localparam int               c_cnt_w = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);
    localparam logic [N-1:0]     c_int_min = {1'b1, {(N-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2*N-1:0]     r_work;   // mul: {acc_hi, multiplier/acc_lo}; div: {rem, dividend/quotient}
    logic [N-1:0]       r_opnd;   // mul: multiplicand magnitude; div: divisor magnitude
    logic               r_neg_q;  // negate product / quotient at the end
    logic               r_neg_r;  // negate remainder at the end
    logic [2:0]         r_op;     // low opcode bits of the running M op
    logic               r_valid;
    logic [N-1:0]       r_data;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [4:0]   w_op;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic         w_accept;
    logic         w_is_mop;
    logic         w_is_div;
    logic         w_div_signed;
    logic         w_b_zero;
    logic         w_ovf;
    logic         w_a_sgn;
    logic         w_b_sgn;
    logic         w_a_neg;
    logic         w_b_neg;
    logic [N-1:0] w_a_mag;
    logic [N-1:0] w_b_mag;
    logic [N-1:0] w_base_res;
    logic [N-1:0] w_bypass;
    logic [N-1:0] w_quick;
    logic         w_start_iter;

    assign w_op         = bus.i_alu_op;
    assign w_a          = bus.i_op_a;
    assign w_b          = bus.i_op_b;
    assign w_accept     = bus.i_valid & bus.o_ready & ~bus.i_flush;
    assign w_is_mop     = is_mdiv_op(w_op);
    assign w_is_div     = w_is_mop & w_op[2];
    assign w_div_signed = ~w_op[0];          // DIV/REM signed, DIVU/REMU unsigned
    assign w_b_zero     = (w_b == '0);
    assign w_ovf        = w_div_signed & (w_a == c_int_min) & (&w_b);

    // Operand signedness: MUL/MULH signed x signed, MULHSU signed x unsigned,
    // MULHU unsigned x unsigned; DIV/REM signed, DIVU/REMU unsigned.
    assign w_a_sgn = w_is_div ? w_div_signed : (w_op[1:0] != 2'b11);
    assign w_b_sgn = w_is_div ? w_div_signed : (w_op[1] == 1'b0);
    assign w_a_neg = w_a_sgn & w_a[N-1];
    assign w_b_neg = w_b_sgn & w_b[N-1];
    // Negating INT_MIN yields itself, which is the correct unsigned magnitude.
    assign w_a_mag = w_a_neg ? (~w_a + 1'b1) : w_a;
    assign w_b_mag = w_b_neg ? (~w_b + 1'b1) : w_b;

    alu_base_n #(
        .N   (N),
        .SHW (SHW)
    ) u_base (
        .i_op_a   (w_a),
        .i_op_b   (w_b),
        .i_alu_op (w_op),
        .o_result (w_base_res)
    );

    // Divide special cases resolved without iterating.
    always_comb begin
        w_bypass = '0;
        if (w_b_zero) begin
            w_bypass = w_op[1] ? w_a : '1;
        end else begin
            w_bypass = w_op[1] ? '0 : w_a;
        end
    end

    assign w_start_iter = w_is_mop & ~(w_is_div & (w_b_zero | w_ovf));
    // Base ops (and 11xxx, which the base unit maps to zero) or divide bypass.
    assign w_quick      = w_is_mop ? w_bypass : w_base_res;

    // ------------------------------------------------------------------
    // One iteration step on the shared working register
    // ------------------------------------------------------------------
    logic [N:0]     w_mul_sum;
    logic [2*N-1:0] w_mul_next;
    logic [N:0]     w_rem_sh;
    logic           w_ge;
    logic [N-1:0]   w_rem_sub;
    logic [N-1:0]   w_rem_new;
    logic [2*N-1:0] w_div_next;
    logic [2*N-1:0] w_work_next;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_sum  = {1'b0, r_work[2*N-1:N]} + (r_work[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_work[N-1:1]};

    // Restoring divide: shift next dividend bit into the partial remainder,
    // subtract the divisor only if it fits; the outcome is the quotient bit.
    // The shifted remainder is kept at N+1 bits since it can reach 2*divisor-1.
    assign w_rem_sh   = r_work[2*N-1:N-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_sub  = w_rem_sh[N-1:0] - r_opnd;
    assign w_rem_new  = w_ge ? w_rem_sub : w_rem_sh[N-1:0];
    assign w_div_next = {w_rem_new, r_work[N-2:0], w_ge};

    assign w_work_next = r_op[2] ? w_div_next : w_mul_next;

    // ------------------------------------------------------------------
    // Sign correction applied to the last iteration's value
    // ------------------------------------------------------------------
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quo;
    logic [N-1:0]   w_rem;
    logic [N-1:0]   w_quo_s;
    logic [N-1:0]   w_rem_s;
    logic [N-1:0]   w_final;

    assign w_prod  = r_neg_q ? (~w_mul_next + 1'b1) : w_mul_next;
    assign w_quo   = w_div_next[N-1:0];
    assign w_rem   = w_div_next[2*N-1:N];
    assign w_quo_s = r_neg_q ? (~w_quo + 1'b1) : w_quo;
    assign w_rem_s = r_neg_r ? (~w_rem + 1'b1) : w_rem;

    always_comb begin
        w_final = '0;
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem_s : w_quo_s;
        end else if (r_op[1:0] == 2'b00) begin
            w_final = w_prod[N-1:0];
        end else begin
            w_final = w_prod[2*N-1:N];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_opnd  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_op    <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_start_iter) begin
                            r_state <= BUSY;
                            r_cnt   <= '0;
                            r_op    <= w_op[2:0];
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            if (w_is_div) begin
                                r_work <= {{N{1'b0}}, w_a_mag};
                                r_opnd <= w_b_mag;
                            end else begin
                                r_work <= {{N{1'b0}}, w_b_mag};
                                r_opnd <= w_a_mag;
                            end
                        end else begin
                            r_valid <= 1'b1;
                            r_data  <= w_quick;
                        end
                    end
                end
                BUSY: begin
                    if (bus.i_flush) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_work <= w_work_next;
                        if (r_cnt == c_last) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_valid <= 1'b1;
                            r_data  <= w_final;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.o_valid    = r_valid;
    assign bus.o_alu_data = r_data;
    assign bus.o_busy     = (r_state == BUSY);
    assign bus.o_ready    = (r_state == IDLE);

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter N, default 32, the operand/result width; legal values are even and >= 8.
REQ-002 SHALL have parameter SHW, default $clog2(N), the shift-amount width taken from i_op_b[SHW-1:0].
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_reset  input  1  reset, synchronous and active-high.
REQ-005 i_valid  input  1  request valid.
REQ-006 o_ready  output  1  unit can accept a request this cycle.
REQ-007 i_op_a  input  N  first operand.
REQ-008 i_op_b  input  N  second operand.
REQ-009 i_alu_op  input  5  opcode; bit4=0 selects base ops, bit4=1 selects multiply/divide ops.
REQ-010 i_flush  input  1  abort any in-flight operation.
REQ-011 o_valid  output  1  one-cycle pulse marking o_alu_data as a result.
REQ-012 o_alu_data  output  N  result; holds its last value while o_valid=0.
REQ-013 o_busy  output  1  iterative operation in progress.

Function
REQ-014 Accept SHALL occur on a rising edge with i_valid=1, o_ready=1 and i_flush=0.
REQ-015 Base opcodes SHALL be ADD 00000, SUB 00001, SLT 00010, SLTU 00011, SRL 00100, SLL 00101, SRA 00110, XOR 01000, OR 01001, AND 01010.
REQ-016 Any other bit4=0 code SHALL produce a result of 0.
REQ-017 Base ops SHALL have latency 1: o_valid=1 in the cycle after accept, with o_ready held high so back-to-back accepts are possible.
REQ-018 ADD and SUB SHALL wrap modulo 2^N.
REQ-019 SLT and SLTU SHALL return 1 or 0, zero-extended to N bits.
REQ-020 Shift amount SHALL be i_op_b[SHW-1:0].
REQ-021 M opcodes SHALL be MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111, with RV32M semantics generalised to N bits; codes 11xxx SHALL return 0 with latency 1.
REQ-022 FSM SHALL have states IDLE and BUSY; IDLE->BUSY on M-op accept; BUSY->IDLE after N iterations or on i_flush.
REQ-023 Multiply SHALL be radix-2 shift-add on operand magnitudes into a 2N-bit accumulator, one bit per cycle, with sign correction after the last iteration.
REQ-024 MUL SHALL return the low N bits of the product; MULH, MULHSU and MULHU SHALL return the high N bits.
REQ-025 Divide SHALL be restoring, one quotient bit per cycle on magnitudes; the quotient sign SHALL be sign(a)^sign(b) and the remainder sign SHALL be sign(a).
REQ-026 M-op latency SHALL be exactly N cycles: o_ready=0 and o_busy=1 during the N BUSY cycles, then o_valid=1 with o_ready=1 in the following cycle.
REQ-027 Divide by zero SHALL bypass BUSY with latency 1: DIV/DIVU return all-ones; REM/REMU return i_op_a.
REQ-028 Signed overflow (DIV/REM with a=2^(N-1), b=-1) SHALL bypass BUSY with latency 1: quotient = a, remainder = 0.
REQ-029 i_flush in BUSY SHALL return the FSM to IDLE next edge with no o_valid; i_flush in IDLE SHALL suppress a pending base-op o_valid.
REQ-030 Operands SHALL be latched at accept; input changes during BUSY SHALL have no effect.
REQ-031 The unit SHALL apply no output backpressure; o_valid is not acknowledged.

Reset
REQ-032 i_reset SHALL take priority over all other inputs, including mid-operation.
REQ-033 Reset SHALL force FSM=IDLE, iteration counter=0, o_valid=0, o_busy=0, o_alu_data=0 and o_ready=1 in the cycle after the reset edge.

Structure
REQ-034 A shared package SHALL hold the 5-bit opcode localparams and the state enum {IDLE, BUSY}.
REQ-035 The single-cycle base-op datapath SHALL be a sub-module alu_base_n, parametrised by N.
REQ-036 Multiply and divide SHALL share one iteration counter and one 2N-bit working register.

Verification (N=32)
REQ-037 Bench SHALL cover: ADD 5,0xFFFFFFFD then SUB 5,7 on consecutive cycles -> o_valid two consecutive cycles, data 2 then 0xFFFFFFFE.
REQ-038 Bench SHALL cover: MULH 0x80000000,0x80000000 -> o_ready=0 for 32 cycles, then o_valid with 0x40000000; MULHU 0xFFFFFFFF,2 -> 1.
REQ-039 Bench SHALL cover: DIV 7,0 -> 0xFFFFFFFF after 1 cycle; REMU 7,0 -> 7 after 1 cycle.
REQ-040 Bench SHALL cover: DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM -> 0; DIV 0xFFFFFFF9,2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-041 Bench SHALL cover: i_flush at BUSY cycle 10 of DIVU -> no o_valid, o_ready=1 next cycle, and a following ADD 1,1 -> 2.
REQ-042 Bench SHALL cover: i_reset at BUSY cycle 5 of MUL -> outputs at reset values next cycle, no o_valid.
